// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common-data-bus arbiter.
// Requester indices double as the CDB source tag carried with every beat.
package cdb_arbiter_pkg;

  localparam int SRC_W = 2;

  typedef enum logic [SRC_W-1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_MUL = 2'd2
  } cdb_src_e;

  // Advance a round-robin index, wrapping at n so it never reaches n.
  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + SRC_W'(1);
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin scan: first valid candidate at or after rr_ptr_i wins.
// Produces a one-hot grant, its index and an any-grant flag.
module cdb_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] cand_valid_i,
  input  logic [SRC_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [SRC_W-1:0] winner_o,
  output logic             any_grant_o
);

  logic found;

  always_comb begin
    grant_o     = '0;
    winner_o    = '0;
    any_grant_o = 1'b0;
    found       = 1'b0;
    // Outer loop is scan distance from rr_ptr; the first hit stops further grants.
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && cand_valid_i[i] && (i == ((int'(rr_ptr_i) + k) % N_REQ))) begin
          found       = 1'b1;
          grant_o[i]  = 1'b1;
          winner_o    = SRC_W'(i);
          any_grant_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per requester, round-robin pick,
// registered CDB beat feeding the ROB result port and operand wakeup.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ROB_POS_W-1:0] req_rob_pos,
  input  logic [N_REQ*DATA_W-1:0]    req_val,
  input  logic [N_REQ-1:0]           req_jump,
  input  logic [N_REQ*DATA_W-1:0]    req_pc,
  output logic                       cdb_valid,
  output logic [ROB_POS_W-1:0]       cdb_rob_pos,
  output logic [DATA_W-1:0]          cdb_val,
  output logic                       cdb_jump,
  output logic [DATA_W-1:0]          cdb_pc,
  output logic [1:0]                 cdb_src
);

  logic [N_REQ-1:0]     hold_valid_q;
  logic [N_REQ-1:0]     hold_valid_d;
  logic [ROB_POS_W-1:0] hold_pos_q  [N_REQ];
  logic [DATA_W-1:0]    hold_val_q  [N_REQ];
  logic                 hold_jump_q [N_REQ];
  logic [DATA_W-1:0]    hold_pc_q   [N_REQ];

  logic [ROB_POS_W-1:0] live_pos  [N_REQ];
  logic [DATA_W-1:0]    live_val  [N_REQ];
  logic [DATA_W-1:0]    live_pc   [N_REQ];

  logic [ROB_POS_W-1:0] cand_pos  [N_REQ];
  logic [DATA_W-1:0]    cand_val  [N_REQ];
  logic                 cand_jump [N_REQ];
  logic [DATA_W-1:0]    cand_pc   [N_REQ];

  logic [N_REQ-1:0] cand_valid;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] xfer;
  logic [N_REQ-1:0] load_en;
  logic [SRC_W-1:0] winner;
  logic             any_grant;
  logic             enable;

  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q;
  logic [ROB_POS_W-1:0] cdb_pos_q, cdb_pos_d;
  logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;
  logic                 cdb_jump_q, cdb_jump_d;
  logic [DATA_W-1:0]    cdb_pc_q, cdb_pc_d;
  logic [SRC_W-1:0]     cdb_src_q;

  assign enable = rdy & ~rollback & ~rst;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign live_pos[gi] = req_rob_pos[gi*ROB_POS_W +: ROB_POS_W];
      assign live_val[gi] = req_val[gi*DATA_W +: DATA_W];
      assign live_pc[gi]  = req_pc[gi*DATA_W +: DATA_W];

      // A held result always outranks the live input of the same requester.
      assign cand_valid[gi] = hold_valid_q[gi] | req_valid[gi];
      assign cand_pos[gi]   = hold_valid_q[gi] ? hold_pos_q[gi]  : live_pos[gi];
      assign cand_val[gi]   = hold_valid_q[gi] ? hold_val_q[gi]  : live_val[gi];
      assign cand_jump[gi]  = hold_valid_q[gi] ? hold_jump_q[gi] : req_jump[gi];
      assign cand_pc[gi]    = hold_valid_q[gi] ? hold_pc_q[gi]   : live_pc[gi];

      assign req_ready[gi] = enable & (~hold_valid_q[gi] | grant[gi]);
      assign xfer[gi]      = req_valid[gi] & req_ready[gi];

      // Store every accepted result except one that goes straight onto the bus.
      assign load_en[gi]      = xfer[gi] & (hold_valid_q[gi] | ~grant[gi]);
      assign hold_valid_d[gi] = load_en[gi] | (hold_valid_q[gi] & ~grant[gi]);
    end
  endgenerate

  cdb_rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .cand_valid_i(cand_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_grant_o (any_grant)
  );

  always_comb begin
    cdb_pos_d  = '0;
    cdb_val_d  = '0;
    cdb_jump_d = 1'b0;
    cdb_pc_d   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cdb_pos_d  = cdb_pos_d  | ({ROB_POS_W{grant[i]}} & cand_pos[i]);
      cdb_val_d  = cdb_val_d  | ({DATA_W{grant[i]}}    & cand_val[i]);
      cdb_jump_d = cdb_jump_d | (grant[i]              & cand_jump[i]);
      cdb_pc_d   = cdb_pc_d   | ({DATA_W{grant[i]}}    & cand_pc[i]);
    end
  end

  assign rr_ptr_d = any_grant ? rr_next(winner, N_REQ) : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      hold_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        hold_pos_q[i]  <= '0;
        hold_val_q[i]  <= '0;
        hold_jump_q[i] <= 1'b0;
        hold_pc_q[i]   <= '0;
      end
    end else if (rdy) begin
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < N_REQ; i++) begin
        if (load_en[i]) begin
          hold_pos_q[i]  <= live_pos[i];
          hold_val_q[i]  <= live_val[i];
          hold_jump_q[i] <= req_jump[i];
          hold_pc_q[i]   <= live_pc[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      cdb_valid_q <= 1'b0;
      cdb_pos_q   <= '0;
      cdb_val_q   <= '0;
      cdb_jump_q  <= 1'b0;
      cdb_pc_q    <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (rdy) begin
      cdb_valid_q <= any_grant;
      rr_ptr_q    <= rr_ptr_d;
      // Idle cycles keep the last beat's fields; only the valid pulse drops.
      if (any_grant) begin
        cdb_pos_q  <= cdb_pos_d;
        cdb_val_q  <= cdb_val_d;
        cdb_jump_q <= cdb_jump_d;
        cdb_pc_q   <= cdb_pc_d;
        cdb_src_q  <= winner;
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_pos = cdb_pos_q;
  assign cdb_val     = cdb_val_q;
  assign cdb_jump    = cdb_jump_q;
  assign cdb_pc      = cdb_pc_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a queue-based reference model
// predicts beats and handshakes, a monitor process checks each new CDB beat.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int PW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst, rdy, rollback;
  logic [N-1:0]    req_valid, req_ready, req_jump;
  logic [N*PW-1:0] req_rob_pos;
  logic [N*DW-1:0] req_val, req_pc;
  logic            cdb_valid, cdb_jump;
  logic [PW-1:0]   cdb_rob_pos;
  logic [DW-1:0]   cdb_val, cdb_pc;
  logic [1:0]      cdb_src;

  cdb_arbiter #(.N_REQ(N), .ROB_POS_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .req_valid(req_valid), .req_ready(req_ready), .req_rob_pos(req_rob_pos),
    .req_val(req_val), .req_jump(req_jump), .req_pc(req_pc),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_pc(cdb_pc), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [PW-1:0] pos;
    logic [DW-1:0] val;
    logic          jump;
    logic [DW-1:0] pc;
  } beat_t;

  beat_t exp_q[$];
  beat_t acc_q[N][$];
  beat_t offer[N];
  bit    offer_v[N];
  int    rr = 0;
  int    load_pct = 0;
  bit    exp_valid = 1'b0;
  bit    exp_zero = 1'b0;
  bit    started = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string name, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic beat_t new_offer(input int i);
    beat_t b;
    b.src  = 2'(i);
    b.pos  = PW'($urandom);
    b.val  = $urandom;
    b.jump = (i == 0) ? 1'($urandom) : 1'b0;
    b.pc   = (i == 0) ? $urandom : 32'h0;
    return b;
  endfunction

  // One clock: check last cycle's prediction, drive inputs, predict this edge.
  task automatic step(input bit r_rdy, input bit r_rb, input bit r_rst);
    int  win;
    bit  en, rdy_exp;
    bit  xf[N];
    bit  live_win;
    beat_t b;
    @(negedge clk);
    if (started) begin
      cmp("cdb_valid", 80'(cdb_valid), 80'(exp_valid));
      if (exp_zero)
        cmp("cdb_fields_zero", 80'({cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, cdb_src}), 80'(0));
    end
    rdy = r_rdy; rollback = r_rb; rst = r_rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = offer_v[i];
      req_rob_pos[i*PW +: PW] = offer[i].pos;
      req_val[i*DW +: DW]   = offer[i].val;
      req_jump[i]           = offer[i].jump;
      req_pc[i*DW +: DW]    = offer[i].pc;
    end
    #1;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i = (rr + k) % N;
      if (win < 0 && (acc_q[i].size() > 0 || offer_v[i])) win = i;
    end
    en = r_rdy && !r_rb && !r_rst;
    for (int i = 0; i < N; i++) begin
      rdy_exp = en && (acc_q[i].size() == 0 || win == i);
      if (started) cmp($sformatf("req_ready%0d", i), 80'(req_ready[i]), 80'(rdy_exp));
      xf[i] = offer_v[i] && rdy_exp;
    end
    if (r_rst || r_rb) begin
      for (int i = 0; i < N; i++) begin
        acc_q[i].delete();
        offer_v[i] = 1'b0;
      end
      rr = 0; exp_valid = 1'b0; exp_zero = 1'b1;
    end else if (en) begin
      live_win = 1'b0;
      if (win >= 0) begin
        if (acc_q[win].size() > 0) begin
          b = acc_q[win].pop_front();
        end else begin
          b = offer[win];
          live_win = 1'b1;
        end
        b.src = 2'(win);
        exp_q.push_back(b);
        exp_valid = 1'b1; exp_zero = 1'b0;
        rr = (win + 1) % N;
      end else begin
        exp_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (xf[i]) begin
          if (!(live_win && i == win)) acc_q[i].push_back(offer[i]);
          offer_v[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!offer_v[i] && $urandom_range(99) < load_pct) begin
        offer_v[i] = 1'b1;
        offer[i] = new_offer(i);
      end
    end
  endtask

  task automatic chk_beat(input string name, input logic [1:0] src, input logic [PW-1:0] pos);
    @(posedge clk); #2;
    cmp({name, "_valid"}, 80'(cdb_valid), 80'(1));
    cmp({name, "_src"}, 80'(cdb_src), 80'(src));
    cmp({name, "_pos"}, 80'(cdb_rob_pos), 80'(pos));
  endtask

  // Monitor: a new beat exists only after an enabled edge.
  initial begin
    bit en_s;
    beat_t e;
    forever begin
      @(posedge clk);
      en_s = rdy && !rollback && !rst;
      #1;
      if (started && en_s && cdb_valid) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_beat", 80'(1), 80'(0));
        end else begin
          e = exp_q.pop_front();
          cmp("beat", 80'({cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc}), 80'(e));
        end
      end
    end
  end

  initial begin
    beat_t b;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    req_valid = '0; req_rob_pos = '0; req_val = '0; req_jump = '0; req_pc = '0;
    for (int i = 0; i < N; i++) begin
      offer_v[i] = 1'b0;
      offer[i] = '0;
    end
    step(1, 0, 1);
    step(1, 0, 1);
    started = 1'b1;

    // Single uncontended ALU result: one-cycle latency, then a single pulse.
    b = '0; b.pos = 4'd5; b.val = 32'h0000_1234; b.jump = 1'b1; b.pc = 32'h100;
    offer[0] = b; offer_v[0] = 1'b1;
    step(1, 0, 0);
    chk_beat("t1", 2'd0, 4'd5);
    cmp("t1_val", 80'(cdb_val), 80'(32'h1234));
    cmp("t1_jump_pc", 80'({cdb_jump, cdb_pc}), 80'({1'b1, 32'h100}));
    step(1, 0, 0);
    step(1, 0, 0);

    // ALU and LSB together from rr_ptr 0; then ALU vs MUL shows rr_ptr at 2.
    step(1, 1, 0);
    b = '0; b.pos = 4'd2; offer[0] = b; offer_v[0] = 1'b1;
    b.pos = 4'd3; b.src = 2'd1; offer[1] = b; offer_v[1] = 1'b1;
    step(1, 0, 0);
    chk_beat("t2a", 2'd0, 4'd2);
    step(1, 0, 0);
    chk_beat("t2b", 2'd1, 4'd3);
    b = '0; b.pos = 4'd7; offer[0] = b; offer_v[0] = 1'b1;
    b.pos = 4'd9; b.src = 2'd2; offer[2] = b; offer_v[2] = 1'b1;
    step(1, 0, 0);
    chk_beat("t2c", 2'd2, 4'd9);
    step(1, 0, 0);
    step(1, 0, 0);

    // Full contention, a rdy stall, a rollback and a reset mid-burst.
    load_pct = 100;
    for (int c = 0; c < 8; c++) step(1, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0);
    for (int c = 0; c < 6; c++) step(1, 0, 0);
    step(1, 1, 0);
    for (int c = 0; c < 4; c++) step(1, 0, 0);
    step(0, 0, 1);
    for (int c = 0; c < 4; c++) step(1, 0, 0);

    // Random traffic with occasional stalls, flushes and resets.
    for (int c = 0; c < 800; c++) begin
      load_pct = (c % 200 < 100) ? 60 : 95;
      step($urandom_range(99) >= 10, $urandom_range(99) < 3, $urandom_range(199) < 1);
    end

    load_pct = 0;
    for (int c = 0; c < 2 * N + 2; c++) step(1, 0, 0);
    cmp("drain_exp_q", 80'(exp_q.size()), 80'(0));
    for (int i = 0; i < N; i++) cmp($sformatf("drain_hold%0d", i), 80'(acc_q[i].size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single ROB result write-back path (the common data bus, CDB) between N_REQ functional-unit requesters: ALU, LSB and MUL by default.
- Each requester gets a 1-entry holding register. The block picks one candidate per cycle by round-robin and drives a registered CDB beat.
- That beat feeds the ROB result port and the RS/LSB operand wakeup.
- Flushes on ROB rollback.

Parameters:
- N_REQ, 3, number of result requesters (index 0 = ALU, 1 = LSB, 2 = MUL).
- ROB_POS_W, 4, width of a ROB index (ROB_SIZE 16).
- DATA_W, 32, result and PC width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state is frozen.
- rollback  in  1  ROB misprediction flush (registered pulse from ROB).
- req_valid  in  N_REQ  requester i has a result.
- req_ready  out  N_REQ  requester i result accepted this cycle.
- req_rob_pos  in  N_REQ*ROB_POS_W  packed ROB index per requester.
- req_val  in  N_REQ*DATA_W  packed result value.
- req_jump  in  N_REQ  branch-taken flag (ALU only; others tie to 0).
- req_pc  in  N_REQ*DATA_W  resolved next PC (ALU only; others tie to 0).
- cdb_valid  out  1  CDB beat valid.
- cdb_rob_pos  out  ROB_POS_W  ROB index of the beat.
- cdb_val  out  DATA_W  result value.
- cdb_jump  out  1  taken flag.
- cdb_pc  out  DATA_W  next PC.
- cdb_src  out  2  index of the winning requester.

Behaviour:
- Reset / flush:
  - rst or rollback acts regardless of rdy.
  - Effect: hold_valid all 0, cdb_valid 0, cdb_rob_pos/cdb_val/cdb_jump/cdb_pc/cdb_src 0, rr_ptr 0.
  - rst has priority over rollback.
- Candidates:
  - cand_valid[i] = hold_valid[i] | req_valid[i].
  - Candidate data is the hold register if hold_valid[i], otherwise the live req_* fields. The hold register always has priority over the live input of the same requester.
- Arbitration:
  - Scan i = rr_ptr, rr_ptr+1, ... mod N_REQ; the first cand_valid wins, giving a one-hot grant.
  - Scan logic is combinational.
- Handshake:
  - req_ready[i] = rdy & ~rollback & ~rst & (~hold_valid[i] | grant[i]).
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Requesters drop or replace a result only after a transfer.
- Per clock edge with rdy=1 and no rst/rollback:
  - If some candidate is granted: cdb_valid<=1, CDB fields <= winner data, cdb_src<=winner, rr_ptr <= (winner+1) mod N_REQ.
  - If no candidate: cdb_valid<=0 and rr_ptr unchanged.
  - Granted hold entry: hold_valid cleared. If its requester transferred a new result the same cycle, that result is loaded into hold instead.
  - Non-granted live transfers (hold empty, not granted) are captured into hold.
  - A live request that wins directly is not stored.
- Latency:
  - Uncontended: 1 cycle (req_valid in cycle t, cdb_valid in t+1).
  - Worst case under full contention: N_REQ cycles.
- Throughput: one CDB beat per cycle; no result is ever dropped or duplicated.
- cdb_valid is a per-beat pulse. Back-to-back beats are allowed.
- rdy=0: no state changes, outputs held, req_ready all 0.
- Wrap-around: rr_ptr wraps N_REQ-1 -> 0. With N_REQ not a power of two, rr_ptr never holds a value >= N_REQ.
- Simultaneous rollback and request: the request is not accepted (req_ready=0) and the beat is not issued. Requesters flush themselves on the same rollback.

Decomposition:
- Shared cons.v supplies ROB_POS_WID, DATA_WID, ADDR_WID and new defines CDB_SRC_ALU=0, CDB_SRC_LSB=1, CDB_SRC_MUL=2.
- One sub-module, cdb_rr_picker:
  - Combinational.
  - Inputs: cand_valid and rr_ptr. Outputs: one-hot grant, winner index, any_grant.
- The top level owns the hold registers, the CDB registers and rr_ptr.

Test Plan:
- After reset, ALU req pos=5 val=0x00001234 jump=1 pc=0x100 for one cycle -> next cycle cdb_valid=1, pos=5, val=0x1234, jump=1, pc=0x100, src=0; following cycle cdb_valid=0.
- rr_ptr=0; ALU (pos 2) and LSB (pos 3) valid the same cycle, both req_ready=1 -> beat ALU pos2, then LSB pos3 from hold; rr_ptr ends at 2.
- All three requesters valid every cycle with fresh pos values -> cdb_src sequence 0,1,2,0,1,2; every accepted pos appears exactly once and in per-requester order.
- LSB and MUL held, rollback pulse -> next cycle cdb_valid=0, req_ready=0 during the rollback cycle, holds empty afterwards, rr_ptr=0; a new ALU request is served in 1 cycle.
- rdy=0 for 3 cycles during contention -> cdb_* and holds frozen, req_ready=0; after rdy returns, grants resume in the same round-robin order.
- rst asserted mid-burst with holds full -> all outputs 0 the next cycle; no stale beat appears after reset is released.
